pwm_deadtime_gen: RTL
=====================

Name: pwm_deadtime_gen

Overview:
Downstream stage of the shadow-register PWM. Consumes its single-ended pwm_out and drives a complementary high-side/low-side gate pair with programmable dead time inserted on every transition. The dead-time value is CPU-written through a shadow register. The new value takes effect only at a PWM period boundary, so a running half-bridge never sees a torn dead-time interval.

Parameters:
DT_W, 8, width of dead-time value in clock cycles
DT_RESET, 4, reset value of both the pending and active dead-time registers

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; 0 forces both gate outputs off
pwm_in  input  1  PWM waveform from the upstream PWM generator, same clock domain, registered at source
dt_data_in  input  DT_W  CPU dead-time value, in cycles
dt_update  input  1  one-cycle strobe; latches dt_data_in into the pending register
pwm_hi  output  1  high-side gate drive, registered
pwm_lo  output  1  low-side gate drive, registered
dt_pend  output  1  high while a written value has not yet been transferred to the active register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pwm_hi=0, pwm_lo=0, dt_pend=0.
  - Pending and active registers = DT_RESET; counter=0.
- Effective dead time D = max(dt_active,1). D=0 is never produced; dt_data_in=0 yields a 1-cycle gap.
- FSM states IDLE, DEAD, LO_ON, HI_ON. Outputs are registered, decoded from the next state:
  - IDLE: 0/0.
  - DEAD: 0/0.
  - LO_ON: pwm_lo=1, pwm_hi=0.
  - HI_ON: pwm_hi=1, pwm_lo=0.
- pwm_hi and pwm_lo are never 1 in the same cycle. This holds under all inputs, including reset.
- Transitions. Edge t is the clock edge at which the condition is sampled:
  - Any state with en=0 -> IDLE at edge t. Both outputs are 0 after t. This has priority over everything else.
  - IDLE with en=1 -> DEAD. Load the active register from pending. Counter = D-1 (computed from the newly loaded value).
  - LO_ON with pwm_in=1 -> DEAD. This is the period start. Load the shadow to active, then counter = D-1.
  - HI_ON with pwm_in=0 -> DEAD. No shadow load. Counter = D-1.
  - DEAD with counter≠0: decrement.
  - DEAD with counter=0: exit to HI_ON if pwm_in=1, else to LO_ON.
- Latency: a pwm_in rise is first sampled at edge t, with the FSM in LO_ON.
  - pwm_lo falls after t.
  - pwm_hi rises after t+D.
  - Both outputs are low for exactly D cycles. The fall transition is symmetric.
- Glitch/short pulses: pwm_in changes while in DEAD are ignored. Only the level at DEAD expiry matters. A pulse narrower than D that returns before expiry is swallowed, and the output returns to its prior side.
- Shadow register:
  - dt_update=1 writes pending <= dt_data_in and sets dt_pend=1.
  - A transfer (IDLE exit or LO_ON->DEAD) copies pending to active and clears dt_pend.
  - A write and a transfer on the same edge: the transfer uses the old pending value, the new value lands in pending, and dt_pend stays 1.
  - Multiple writes before a transfer: the last write wins.
  - en=0 does not block writes.
- Steady pwm_in=1 (100% duty): stays HI_ON indefinitely. The shadow never transfers until pwm_in falls and rises again or en cycles.
- Counter width is DT_W. There is no wrap, because the counter is loaded only with D-1 ≤ 2^DT_W-2.

Optional Feature:
Macro PWM_DT_FAULT_EN.
- Defined:
  - Adds input fault_in (1 bit) and input fault_clr (1 bit) and output fault_latched (1 bit).
  - fault_in=1 sampled at any edge forces state FAULT at that edge, with both outputs 0 after it and fault_latched=1.
  - FAULT has priority over en.
  - FAULT exits to IDLE only on fault_clr=1 with fault_in=0.
  - Reset clears fault_latched.
- Undefined: no fault ports; FSM has four states.

Test Plan:
- Reset/enable: rst_n low then high, en=1, pwm_in=0, DT_RESET=4 -> 0/0 for 4 cycles after en sampled, then pwm_lo=1. Both outputs 0 throughout reset.
- Rising and falling dead time: D=4, pwm_in high for 20 cycles -> pwm_lo falls at t, pwm_hi rises at t+4. On pwm_in fall, pwm_hi drops and pwm_lo returns 4 cycles later. Overlap checker never fires.
- Shadow update mid-period: active=4. Write dt_data_in=10 while in HI_ON -> dt_pend=1, and the current falling gap is still 4 cycles. The next rising gap is 10 cycles and dt_pend clears at that edge.
- Short pulse: D=6, pwm_in high for 3 cycles -> pwm_hi never asserts, pwm_lo restored after the 6-cycle gap. With dt_data_in=0 transferred, the gap is exactly 1 cycle.
- en drop in DEAD and async reset in HI_ON -> outputs 0 on the same edge (en) or immediately (rst_n); re-enable restarts with a full D gap.
- PWM_DT_FAULT_EN: fault_in pulse during HI_ON -> outputs 0 next edge, fault_latched=1. en toggling has no effect. fault_clr -> IDLE then the DEAD entry sequence.

Source files
------------

// File: rtl/pwm_deadtime_gen.sv
// rtl/pwm_deadtime_gen.sv - complementary gate driver with shadowed dead-time insertion
//
// Turns a single-ended PWM waveform into a high-side/low-side gate pair. Both
// gates are held off for D = max(dt_active,1) cycles around every transition.
// The dead-time value is written into a pending (shadow) register by the CPU
// and copied into the active register only at a period start (LO_ON -> DEAD)
// or when leaving IDLE, so a running bridge never sees a torn gap.
//
// Optional build macro: PWM_DT_FAULT_EN adds a latched fault shutdown.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   en            block enable; 0 forces both gates off
//   pwm_in        upstream PWM waveform (same clock domain, registered)
//   dt_data_in    CPU dead-time value in cycles
//   dt_update     one-cycle strobe, writes dt_data_in into the pending register
//   pwm_hi        high-side gate drive (registered)
//   pwm_lo        low-side gate drive (registered)
//   dt_pend       a written value is waiting to be transferred
//   fault_in      (PWM_DT_FAULT_EN) fault request, forces FAULT
//   fault_clr     (PWM_DT_FAULT_EN) leave FAULT when fault_in is low
//   fault_latched (PWM_DT_FAULT_EN) high while in FAULT

module pwm_deadtime_gen #(
  parameter int DT_W              = 8,
  parameter int unsigned DT_RESET = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dt_data_in,
  input  logic            dt_update,
`ifdef PWM_DT_FAULT_EN
  input  logic            fault_in,
  input  logic            fault_clr,
  output logic            fault_latched,
`endif
  output logic            pwm_hi,
  output logic            pwm_lo,
  output logic            dt_pend
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEAD  = 3'd1,
    ST_LO_ON = 3'd2,
    ST_HI_ON = 3'd3
`ifdef PWM_DT_FAULT_EN
    ,
    ST_FAULT = 3'd4
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [DT_W-1:0] cnt, cnt_nxt;
  logic [DT_W-1:0] dt_pending;
  logic [DT_W-1:0] dt_active;
  logic            xfer;       // copy pending -> active on this edge
  logic            gap_start;  // entering DEAD from a driven/idle state
  logic [DT_W-1:0] dt_src;
  logic [DT_W-1:0] dt_eff;
  logic            hi_nxt, lo_nxt;
`ifdef PWM_DT_FAULT_EN
  logic            flt_nxt;
`endif

  // The gap length comes from the value that will be active after this edge:
  // the old pending value on a transfer, otherwise the current active value.
  assign dt_src = xfer ? dt_pending : dt_active;
  assign dt_eff = (dt_src == '0) ? DT_W'(1) : dt_src;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dt_pending <= DT_W'(DT_RESET);
      dt_active  <= DT_W'(DT_RESET);
      dt_pend    <= 1'b0;
      pwm_hi     <= 1'b0;
      pwm_lo     <= 1'b0;
`ifdef PWM_DT_FAULT_EN
      fault_latched <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pwm_hi <= hi_nxt;
      pwm_lo <= lo_nxt;
`ifdef PWM_DT_FAULT_EN
      fault_latched <= flt_nxt;
`endif
      if (xfer) begin
        dt_active <= dt_pending;
      end
      // A write on the same edge as a transfer lands after it: the transfer
      // took the old pending value, so the flag must stay set.
      if (dt_update) begin
        dt_pending <= dt_data_in;
        dt_pend    <= 1'b1;
      end else if (xfer) begin
        dt_pend <= 1'b0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    xfer      = 1'b0;
    gap_start = 1'b0;
`ifdef PWM_DT_FAULT_EN
    if (fault_in) begin
      state_nxt = ST_FAULT;
    end else if (state == ST_FAULT) begin
      if (fault_clr) begin
        state_nxt = ST_IDLE;
      end
    end else
`endif
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_DEAD;
          xfer      = 1'b1;
          gap_start = 1'b1;
        end
        ST_LO_ON: begin
          // Rising edge of pwm_in marks the period start: safe point to
          // pick up a new dead-time value.
          if (pwm_in) begin
            state_nxt = ST_DEAD;
            xfer      = 1'b1;
            gap_start = 1'b1;
          end
        end
        ST_HI_ON: begin
          if (!pwm_in) begin
            state_nxt = ST_DEAD;
            gap_start = 1'b1;
          end
        end
        ST_DEAD: begin
          // pwm_in is ignored until the gap expires; only its level at
          // expiry picks the side, which swallows short pulses.
          if (cnt != '0) begin
            cnt_nxt = cnt - DT_W'(1);
          end else begin
            state_nxt = pwm_in ? ST_HI_ON : ST_LO_ON;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
    if (gap_start) begin
      cnt_nxt = dt_eff - DT_W'(1);
    end
  end

  // Output decode from the next state; registered in the state process so
  // the gates change on the same edge as the state.
  always_comb begin
    hi_nxt = (state_nxt == ST_HI_ON);
    lo_nxt = (state_nxt == ST_LO_ON);
`ifdef PWM_DT_FAULT_EN
    flt_nxt = (state_nxt == ST_FAULT);
`endif
  end

endmodule
